// File: rtl/cic_decim30.sv
// Third-order CIC decimator, R=30, M=1: integrators run on the base-band enable,
// a four-state comb sequencer produces one audio sample per capture.
module cic_decim30 #(
  parameter int W_IN  = 16,
  parameter int W_OUT = 16,
  parameter int W_ACC = 31
) (
  input  logic                    clk240m,
  input  logic                    reset_n,
  input  logic                    en960k,
  input  logic                    en32k,
  input  logic signed [W_IN-1:0]  in_data,
  output logic signed [W_OUT-1:0] out_data,
  output logic                    out_valid,
  output logic                    err
);

  if (W_ACC < W_IN + 15) begin : g_bad_w_acc
    $error("cic_decim30: W_ACC must be at least W_IN+15");
  end

  typedef enum logic [1:0] {IDLE, C1, C2, C3} state_t;

  state_t                   state_q, state_d;
  logic signed [W_ACC-1:0]  i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic signed [W_ACC-1:0]  w_q, w_d;
  logic signed [W_ACC-1:0]  xp1_q, xp1_d, xp2_q, xp2_d, xp3_q, xp3_d;
  logic signed [W_ACC-1:0]  d3;
  logic signed [W_OUT-1:0]  out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     err_q, err_d;

  function automatic logic signed [W_ACC-1:0] sext_in(input logic signed [W_IN-1:0] x);
    return {{(W_ACC-W_IN){x[W_IN-1]}}, x};
  endfunction

  // Keep the top W_OUT bits: plain truncation, i.e. floor toward -inf.
  function automatic logic signed [W_OUT-1:0] trunc_out(input logic signed [W_ACC-1:0] d);
    return d[W_ACC-1 -: W_OUT];
  endfunction

  always_comb begin
    state_d     = state_q;
    i1_d        = i1_q;
    i2_d        = i2_q;
    i3_d        = i3_q;
    w_d         = w_q;
    xp1_d       = xp1_q;
    xp2_d       = xp2_q;
    xp3_d       = xp3_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    d3          = w_q - xp3_q;

    // Integrator stage: every source term is the pre-update value.
    if (en960k) begin
      i1_d = i1_q + sext_in(in_data);
      i2_d = i2_q + i1_q;
      i3_d = i3_q + i2_q;
    end

    if (en32k && (!en960k || state_q != IDLE)) err_d = 1'b1;

    // Comb stages: w carries x, D1, D2 through C1..C3.
    case (state_q)
      IDLE: begin
        if (en32k && en960k) begin
          w_d     = i3_q;
          state_d = C1;
        end
      end
      C1: begin
        w_d     = w_q - xp1_q;
        xp1_d   = w_q;
        state_d = C2;
      end
      C2: begin
        w_d     = w_q - xp2_q;
        xp2_d   = w_q;
        state_d = C3;
      end
      C3: begin
        xp3_d       = w_q;
        out_data_d  = trunc_out(d3);
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk240m or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      w_q         <= '0;
      xp1_q       <= '0;
      xp2_q       <= '0;
      xp3_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      w_q         <= w_d;
      xp1_q       <= xp1_d;
      xp2_q       <= xp2_d;
      xp3_q       <= xp3_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: doc/cic_decim30.md
CIC_DECIM30 -- requirements
Module: cic_decim30

Interface
REQ-001 Parameter W_IN, default 16: input sample width, signed two's complement.
REQ-002 Parameter W_OUT, default 16: output sample width, signed two's complement.
REQ-003 Parameter W_ACC, default 31 (W_IN+15): integrator/comb width; SHALL be at least W_IN+15.
REQ-004 clk240m  input  1  240 MHz clock; the only clock.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 en960k  input  1  base-band clock enable; one clk240m cycle wide.
REQ-007 en32k  input  1  audio clock enable; one cycle wide, nominally coincident with every 30th en960k.
REQ-008 in_data  input  W_IN  base-band sample; sampled only in en960k cycles.
REQ-009 out_data  output  W_OUT  decimated audio sample.
REQ-010 out_valid  output  1  one-cycle strobe; out_data is new in this cycle.
REQ-011 err  output  1  sticky protocol-error flag.

Function
REQ-012 Block SHALL be a 3rd-order CIC decimator: rate R=30, differential delay M=1, DC gain 27000.
REQ-013 Integrators I1..I3 (W_ACC bits) SHALL update only in en960k cycles: I1+=sext(in_data), I2+=I1, I3+=I2, each using the pre-update value of its source.
REQ-014 All integrator and comb arithmetic SHALL be modulo 2^W_ACC, with wrap-around and no saturation.
REQ-015 A cycle with en32k=1 and en960k=1 SHALL capture the pre-update I3 into the comb pipeline and start the comb sequence.
REQ-016 Comb FSM states: IDLE, C1, C2, C3.
REQ-017 Comb FSM transitions: IDLE->C1 on a capture; C1->C2, C2->C3, C3->IDLE unconditionally, one cycle each.
REQ-018 C1 SHALL compute D1 = x - x_prev1, with x_prev1 updated to x.
REQ-019 C2 SHALL compute D2 = D1 - x_prev2, with x_prev2 updated to D1.
REQ-020 C3 SHALL compute D3 = D2 - x_prev3, with x_prev3 updated to D2.
REQ-021 In the C3->IDLE transition cycle, out_data SHALL load D3[W_ACC-1 -: W_OUT] (truncation, floor toward -inf) and out_valid SHALL be 1 for exactly that cycle.
REQ-022 Latency SHALL be 4 clk240m cycles from the en32k capture cycle to out_valid; out_data SHALL hold its value until the next out_valid.
REQ-023 en32k=1 with en960k=0 SHALL be ignored for capture and SHALL set err.
REQ-024 A capture request while the FSM is not IDLE SHALL be ignored and SHALL set err.
REQ-025 err SHALL clear only on reset.
REQ-026 in_data SHALL be ignored outside en960k cycles.
REQ-027 en960k and en32k coincident SHALL perform both the integrator update (REQ-013) and the capture (REQ-015) in the same cycle.
REQ-028 With a constant input x, output SHALL be floor(x*27000/32768) from the 5th out_valid onward.

Reset
REQ-029 While reset_n=0, I1..I3, comb delays and out_data SHALL be 0, out_valid=0, err=0, and the FSM SHALL be IDLE.
REQ-030 Assertion of reset_n SHALL take effect immediately, mid-sequence included, with no out_valid pulse after assertion.
REQ-031 Operation SHALL resume on the first en960k after deassertion; no out_valid SHALL occur before the first valid capture.

Verification
REQ-032 in_data=1000 constant, nominal strobes -> out_data=823 from 5th out_valid; out_valid period exactly 7500 clk240m cycles.
REQ-033 in_data=-1000 constant -> out_data=-824; in_data=32767 -> 26999; in_data=-32768 -> -27000; integrators wrap without error.
REQ-034 Single impulse in_data=32767 for one en960k, then 0 -> sum of the outputs ~ 26999 (+/-3 truncation), output returns to 0 within 4 out_valid.
REQ-035 Stray en32k without en960k -> no out_valid, err=1.
REQ-036 Second en32k 2 cycles after a capture -> ignored, err=1.
REQ-037 reset_n pulsed low during state C2 -> out_valid stays 0, all state 0; after release, DC test REQ-032 passes again.
